// File: rtl/tdc_ts_collector_pkg.sv
// ============================================================================
// Module      : tdc_ts_collector_pkg
// Description : Shared defaults and helpers for the multi-channel TDC
//               timestamp collector (channel count, coarse width, FIFO depth,
//               fine-code width, drop-counter type).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tdc_ts_collector_pkg;

    // Block-level defaults shared with the rest of the TDC design.
    localparam int TS_NUM_CH     = 4;
    localparam int TS_COARSE_W   = 16;
    localparam int TS_FIFO_DEPTH = 16;

    // Width of the binary fine code produced by the delay-line encoders.
    localparam int DIG_OUT       = 8;

    // Dropped-hit counter width (saturating).
    localparam int DROP_CNT_W    = 16;

    typedef logic [DROP_CNT_W-1:0] drop_cnt_t;

    // Channel-index width; a single channel still needs one bit.
    function automatic int f_ch_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/tdc_ts_fifo.sv
// ============================================================================
// Module      : tdc_ts_fifo
// Description : Synchronous first-word-fall-through FIFO with full/empty.
//               oData presents the head entry whenever the FIFO is non-empty
//               and reads as zero when empty.
// Ports       : iClk, iRst (sync, active-high)
//               iPush/iData  - write side, ignored while full
//               iPop         - advance the head, ignored while empty
//               oData        - head entry
//               oFull/oEmpty - occupancy flags (before any same-cycle pop)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_ts_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iPush,
    input  logic [WIDTH-1:0] iData,
    input  logic             iPop,
    output logic [WIDTH-1:0] oData,
    output logic             oFull,
    output logic             oEmpty
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_cnt_w-1:0] r_count;

    logic w_do_push;
    logic w_do_pop;

    assign oFull     = (r_count == c_cnt_w'(DEPTH));
    assign oEmpty    = (r_count == '0);
    assign w_do_push = iPush & ~oFull;
    assign w_do_pop  = iPop & ~oEmpty;

    // Gate the head with empty so stale storage never leaks onto the port.
    assign oData = oEmpty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + c_cnt_w'(1);
                2'b01:   r_count <= r_count - c_cnt_w'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked by the count.
    always_ff @(posedge iClk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= iData;
        end
    end

endmodule

`default_nettype wire

// File: rtl/tdc_ts_collector.sv
// ============================================================================
// Module      : tdc_ts_collector
// Description : Multi-channel TDC timestamp collector. Pairs each channel's
//               fine code with a free-running coarse count, holds one hit per
//               channel, arbitrates round-robin into a FWFT FIFO and reports
//               dropped hits.
// Ports       : iClk, iRst (sync, active-high), iEn
//               iFine/iFineValid - per-channel fine codes and strobes
//               oData/oValid/iReady - {channel, coarse, fine} readout
//               oOverflow - sticky dropped-hit flag
//               oDropCnt  - saturating dropped-hit count
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tdc_ts_collector
    import tdc_ts_collector_pkg::*;
#(
    parameter int  NUM_CH     = TS_NUM_CH,
    parameter int  FINE_W     = DIG_OUT,
    parameter int  COARSE_W   = TS_COARSE_W,
    parameter int  FIFO_DEPTH = TS_FIFO_DEPTH,
    localparam int CH_W       = f_ch_w(NUM_CH),
    localparam int WORD_W     = CH_W + COARSE_W + FINE_W
) (
    input  logic                     iClk,
    input  logic                     iRst,
    input  logic                     iEn,
    input  logic [NUM_CH*FINE_W-1:0] iFine,
    input  logic [NUM_CH-1:0]        iFineValid,
    output logic [WORD_W-1:0]        oData,
    output logic                     oValid,
    input  logic                     iReady,
    output logic                     oOverflow,
    output logic [DROP_CNT_W-1:0]    oDropCnt
);

    localparam int              c_sum_w   = DROP_CNT_W + 1;
    // Last-granted pointer starts at the top channel so channel 0 wins first.
    localparam logic [CH_W-1:0] c_rr_init = CH_W'(NUM_CH - 1);

    logic [COARSE_W-1:0] r_coarse;
    logic [NUM_CH-1:0]   r_pend;
    logic [COARSE_W-1:0] r_hold_coarse [NUM_CH];
    logic [FINE_W-1:0]   r_hold_fine   [NUM_CH];
    logic [CH_W-1:0]     r_last;
    logic                r_overflow;
    drop_cnt_t           r_drop_cnt;

    logic                w_fifo_full;
    logic                w_fifo_empty;
    logic                w_grant_vld;
    logic [CH_W-1:0]     w_grant_idx;
    logic [NUM_CH-1:0]   w_grant_oh;
    logic [NUM_CH-1:0]   w_strobe;
    logic [NUM_CH-1:0]   w_accept;
    logic [NUM_CH-1:0]   w_drop;
    logic [c_sum_w-1:0]  w_drop_sum;
    drop_cnt_t           w_drop_next;
    logic [WORD_W-1:0]   w_push_data;

    // Round-robin search from r_last+1. The first pass picks the lowest
    // pending channel at or below r_last (the wrapped part of the search);
    // the second pass overrides it with the lowest pending channel above
    // r_last, which comes earlier in the search order.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant_idx = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (r_pend[k] && (CH_W'(k) <= r_last)) begin
                w_grant_vld = 1'b1;
                w_grant_idx = CH_W'(k);
            end
        end
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            if (r_pend[k] && (CH_W'(k) > r_last)) begin
                w_grant_vld = 1'b1;
                w_grant_idx = CH_W'(k);
            end
        end
        // Full is judged before any same-cycle pop.
        if (w_fifo_full) begin
            w_grant_vld = 1'b0;
        end
    end

    always_comb begin
        w_grant_oh = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_grant_oh[k] = w_grant_vld && (w_grant_idx == CH_W'(k));
        end
    end

    // A register being granted this cycle counts as free for a new strobe.
    assign w_strobe = iFineValid & {NUM_CH{iEn}};
    assign w_accept = w_strobe & (~r_pend | w_grant_oh);
    assign w_drop   = w_strobe & r_pend & ~w_grant_oh;

    // Every dropped hit counts, even several in one cycle; saturate at max.
    always_comb begin
        w_drop_sum = {1'b0, r_drop_cnt};
        for (int k = 0; k < NUM_CH; k++) begin
            w_drop_sum = w_drop_sum + c_sum_w'(w_drop[k]);
        end
        w_drop_next = w_drop_sum[DROP_CNT_W] ? '1 : w_drop_sum[DROP_CNT_W-1:0];
    end

    assign w_push_data = {w_grant_idx, r_hold_coarse[w_grant_idx], r_hold_fine[w_grant_idx]};

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_pend <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                r_hold_coarse[k] <= '0;
                r_hold_fine[k]   <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (w_accept[k]) begin
                    r_pend[k]        <= 1'b1;
                    r_hold_coarse[k] <= r_coarse;
                    r_hold_fine[k]   <= iFine[k*FINE_W +: FINE_W];
                end else if (w_grant_oh[k]) begin
                    r_pend[k] <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            r_coarse   <= '0;
            r_last     <= c_rr_init;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (iEn) begin
                r_coarse <= r_coarse + COARSE_W'(1);
            end
            if (w_grant_vld) begin
                r_last <= w_grant_idx;
            end
            if (|w_drop) begin
                r_overflow <= 1'b1;
            end
            r_drop_cnt <= w_drop_next;
        end
    end

    tdc_ts_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iClk   (iClk),
        .iRst   (iRst),
        .iPush  (w_grant_vld),
        .iData  (w_push_data),
        .iPop   (iReady),
        .oData  (oData),
        .oFull  (w_fifo_full),
        .oEmpty (w_fifo_empty)
    );

    assign oValid    = ~w_fifo_empty;
    assign oOverflow = r_overflow;
    assign oDropCnt  = r_drop_cnt;

endmodule

`default_nettype wire

// File: tb/tb_tdc_ts_collector.sv
// ============================================================================
// Module      : tb_tdc_ts_collector
// Description : Self-checking bench for tdc_ts_collector (4 channels, 8-bit
//               fine, 4-bit coarse so the wrap is reachable, 16-deep FIFO).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_tdc_ts_collector;

    localparam int NUM_CH     = 4;
    localparam int FINE_W     = 8;
    localparam int COARSE_W   = 4;
    localparam int FIFO_DEPTH = 16;
    localparam int CH_W       = 2;
    localparam int WORD_W     = CH_W + COARSE_W + FINE_W;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en;
    logic                     ready;
    logic [NUM_CH*FINE_W-1:0] fine;
    logic [NUM_CH-1:0]        fv;
    logic [WORD_W-1:0]        data;
    logic                     valid;
    logic                     ovf;
    logic [15:0]              dcnt;

    always #5 clk = ~clk;

    tdc_ts_collector #(
        .NUM_CH     (NUM_CH),
        .FINE_W     (FINE_W),
        .COARSE_W   (COARSE_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .iClk       (clk),
        .iRst       (rst),
        .iEn        (en),
        .iFine      (fine),
        .iFineValid (fv),
        .oData      (data),
        .oValid     (valid),
        .iReady     (ready),
        .oOverflow  (ovf),
        .oDropCnt   (dcnt)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", nm, act, req, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int                m_coarse;
    bit                m_pend [NUM_CH];
    logic [WORD_W-1:0] m_word [NUM_CH];
    int                m_last;
    logic [WORD_W-1:0] m_q [$];
    bit                m_ovf;
    int                m_drops;
    bit                m_live = 1'b0;

    always @(posedge clk) begin
        int g;
        int nd;
        if (rst) begin
            m_coarse = 0;
            m_last   = NUM_CH - 1;
            m_q.delete();
            m_ovf    = 1'b0;
            m_drops  = 0;
            for (int k = 0; k < NUM_CH; k++) m_pend[k] = 1'b0;
            m_live   = 1'b1;
        end else begin
            g = -1;
            if (m_q.size() < FIFO_DEPTH) begin
                for (int i = 1; i <= NUM_CH; i++) begin
                    if (g < 0 && m_pend[(m_last + i) % NUM_CH]) g = (m_last + i) % NUM_CH;
                end
            end
            if (m_q.size() > 0 && ready) void'(m_q.pop_front());
            if (g >= 0) begin
                m_q.push_back(m_word[g]);
                m_pend[g] = 1'b0;
                m_last    = g;
            end
            nd = 0;
            if (en) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    if (fv[k]) begin
                        if (!m_pend[k]) begin
                            m_pend[k] = 1'b1;
                            m_word[k] = {CH_W'(k), COARSE_W'(m_coarse), fine[k*FINE_W +: FINE_W]};
                        end else begin
                            nd++;
                        end
                    end
                end
                m_coarse = (m_coarse + 1) % (1 << COARSE_W);
            end
            m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
            if (nd > 0) m_ovf = 1'b1;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (m_live) begin
            chk("valid", valid, m_q.size() > 0);
            chk("data", data, (m_q.size() > 0) ? m_q[0] : '0);
            chk("overflow", ovf, m_ovf);
            chk("drop_cnt", dcnt, m_drops);
        end
    end

    // Words actually handed to the consumer.
    logic [WORD_W-1:0] got [$];
    always @(negedge clk) begin
        if (m_live && !rst && valid && ready) got.push_back(data);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_coarse(input int v);
        int n;
        n = 0;
        while (m_coarse != v && n < 64) begin
            tick();
            n++;
        end
        if (m_coarse != v) begin
            n_cmp++;
            n_fail++;
            $display("FAIL wait_coarse: coarse %0d, required %0d", m_coarse, v);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; ready = 1'b1; fine = '0; fv = '0;
        tick(); tick();
        chk("rst_valid", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_dcnt", dcnt, 0);
        rst = 1'b0; en = 1'b1;

        // Single hit on ch2 at coarse 10.
        got.delete();
        wait_coarse(10);
        fine = '0; fine[2*FINE_W +: FINE_W] = 8'h5A; fv = 4'b0100;
        tick(); fv = '0;
        chk("t1_valid_t1", valid, 0);
        tick();
        chk("t1_valid_t2", valid, 1);
        chk("t1_word", data, {2'd2, 4'd10, 8'h5A});
        repeat (3) tick();
        chk("t1_count", got.size(), 1);
        chk("t1_ovf", ovf, 0);

        // Simultaneous hits from a fresh RR pointer, then ch0+ch3.
        rst = 1'b1; tick(); rst = 1'b0;
        got.delete();
        wait_coarse(7);
        fine = {8'd4, 8'd3, 8'd2, 8'd1}; fv = 4'hF;
        tick(); fv = '0;
        repeat (8) tick();
        chk("t2_count", got.size(), 4);
        for (int k = 0; k < 4; k++) begin
            if (k < got.size()) chk("t2_order", got[k], {CH_W'(k), 4'd7, 8'(k + 1)});
        end
        got.delete();
        wait_coarse(12);
        fine = {8'h33, 8'h00, 8'h00, 8'h11}; fv = 4'b1001;
        tick(); fv = '0;
        repeat (6) tick();
        chk("t2b_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t2b_first", got[0], {2'd0, 4'd12, 8'h11});
            chk("t2b_second", got[1], {2'd3, 4'd12, 8'h33});
        end

        // Backpressure: 18 strobes on ch1 with no readout.
        got.delete();
        ready = 1'b0;
        wait_coarse(1);
        for (int i = 0; i < 18; i++) begin
            fine = '0; fine[1*FINE_W +: FINE_W] = 8'(i); fv = 4'b0010;
            tick();
        end
        fv = '0;
        chk("t3_dcnt", dcnt, 1);
        chk("t3_ovf", ovf, 1);
        chk("t3_valid", valid, 1);
        ready = 1'b1;
        repeat (22) tick();
        chk("t3_drained", got.size(), 17);
        for (int i = 0; i < 17; i++) begin
            if (i < got.size()) chk("t3_word", got[i], {2'd1, 4'((1 + i) % 16), 8'(i)});
        end
        chk("t3_empty", valid, 0);

        // Coarse wrap 15 -> 0.
        got.delete();
        wait_coarse(15);
        fine = '0; fine[0 +: FINE_W] = 8'hA0; fv = 4'b0001;
        tick();
        fine[0 +: FINE_W] = 8'hA1;
        tick(); fv = '0;
        repeat (5) tick();
        chk("t4_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("t4_c15", got[0], {2'd0, 4'd15, 8'hA0});
            chk("t4_c0", got[1], {2'd0, 4'd0, 8'hA1});
        end

        // Disabled strobes are ignored.
        got.delete();
        en = 1'b0; fv = 4'b0001;
        repeat (5) tick();
        fv = '0;
        tick(); tick();
        chk("t5_no_words", got.size(), 0);
        chk("t5_no_valid", valid, 0);
        chk("t5_dcnt_hold", dcnt, 1);

        // Buffer five words then reset mid-operation.
        en = 1'b1; ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fine = '0; fine[0 +: FINE_W] = 8'(8'h40 + i); fv = 4'b0001;
            tick();
        end
        fv = '0;
        repeat (3) tick();
        chk("t5_model_depth", m_q.size(), 5);
        chk("t5_buffered_valid", valid, 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t5_rst_valid", valid, 0);
        chk("t5_rst_dcnt", dcnt, 0);
        chk("t5_rst_ovf", ovf, 0);
        ready = 1'b1;
        fine = '0; fine[2*FINE_W +: FINE_W] = 8'h77; fv = 4'b0100;
        tick(); fv = '0;
        repeat (4) tick();
        chk("t5_post_count", got.size(), 1);
        if (got.size() == 1) chk("t5_post_word", got[0], {2'd2, 4'd0, 8'h77});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
